// File: rtl/hpdmc_wrdatapath.sv
// hpdmc_wrdatapath: write-data launch stage of the HPDMC DDR controller.
// For each accepted WRITE command it steps through the DQS preamble, the data
// burst and the DQS postamble. It presents the rising and falling halves of
// DQ/DM/DQS to the per-byte output registers and drives the output enables.
// Write data is pulled from the buffer one cycle before it is launched.
// A beat that is missing when requested is masked rather than stalled,
// because DRAM write timing cannot slip.
module hpdmc_wrdatapath #(
   parameter int DQW          = 32,
   parameter int DMW          = DQW / 8,
   parameter int WL_CYCLES    = 1,
   parameter int BURST_CYCLES = 2
) (
   input  logic             sys_clk,
   input  logic             sdram_rst,
   input  logic             write_start,
   output logic             write_ready,
   input  logic             di_valid,
   output logic             di_ready,
   input  logic [2*DQW-1:0] di,
   input  logic [2*DMW-1:0] dm,
   output logic [DQW-1:0]   dq_d0,
   output logic [DQW-1:0]   dq_d1,
   output logic [DMW-1:0]   dm_d0,
   output logic [DMW-1:0]   dm_d1,
   output logic             dqs_d0,
   output logic             dqs_d1,
   output logic             dq_oe,
   output logic             dqs_oe,
   output logic             busy,
   output logic             underrun,
   input  logic             underrun_clr
);

   // One counter serves both PRE and BURST, so size it for the longer phase.
   localparam int CNT_MAX = (WL_CYCLES > BURST_CYCLES) ? WL_CYCLES : BURST_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] PRE_LAST   = CW'(WL_CYCLES - 1);
   localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   localparam logic [DQW-1:0] DQ_IDLE = {DQW{1'b0}};
   localparam logic [DMW-1:0] DM_IDLE = {DMW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_BURST = 2'd2,
      ST_POST  = 2'd3
   } state_t;

   state_t         state_r, state_s;
   logic [CW-1:0]  cnt_r, cnt_s;
   logic           from_post_r, from_post_s;

   logic           pre_last_s;
   logic           burst_last_s;
   logic           write_ready_s;
   logic           di_ready_s;
   logic           take_s;
   logic           miss_s;

   logic [DQW-1:0] dq_d0_s, dq_d1_s;
   logic [DQW-1:0] dq_d0_r, dq_d1_r;
   logic [DMW-1:0] dm_d0_s, dm_d1_s;
   logic [DMW-1:0] dm_d0_r, dm_d1_r;
   logic           dqs_d0_s, dqs_d1_s, dq_oe_s, dqs_oe_s, busy_s, underrun_s;
   logic           dqs_d0_r, dqs_d1_r, dq_oe_r, dqs_oe_r, busy_r, underrun_r;

   // Handshake decode: depends only on the current state and counter.
   always_comb begin
      pre_last_s    = 1'b0;
      burst_last_s  = 1'b0;
      write_ready_s = 1'b0;
      di_ready_s    = 1'b0;
      take_s        = 1'b0;
      miss_s        = 1'b0;
      if (state_r == ST_PRE) begin
         pre_last_s = (cnt_r == PRE_LAST);
      end else begin
         pre_last_s = 1'b0;
      end
      if (state_r == ST_BURST) begin
         burst_last_s = (cnt_r == BURST_LAST);
      end else begin
         burst_last_s = 1'b0;
      end
      write_ready_s = (state_r == ST_IDLE) || (state_r == ST_POST);
      // One beat is requested in the last preamble cycle and in every burst
      // cycle except the last, which gives exactly BURST_CYCLES requests.
      di_ready_s    = pre_last_s || ((state_r == ST_BURST) && !burst_last_s);
      take_s        = di_ready_s && di_valid;
      miss_s        = di_ready_s && !di_valid;
   end

   // Next-state logic for the IDLE/PRE/BURST/POST sequencer.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      from_post_s = from_post_r;
      case (state_r)
         ST_IDLE: begin
            if (write_start) begin
               state_s     = ST_PRE;
               cnt_s       = CNT_ZERO;
               from_post_s = 1'b0;
            end else begin
               state_s     = ST_IDLE;
               cnt_s       = CNT_ZERO;
            end
         end
         ST_PRE: begin
            if (pre_last_s) begin
               state_s = ST_BURST;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_BURST: begin
            if (burst_last_s) begin
               state_s = ST_POST;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         ST_POST: begin
            // A write issued during the postamble chains straight into a new
            // preamble; DQS stays driven across the gap.
            if (write_start) begin
               state_s     = ST_PRE;
               cnt_s       = CNT_ZERO;
               from_post_s = 1'b1;
            end else begin
               state_s     = ST_IDLE;
               cnt_s       = CNT_ZERO;
               from_post_s = 1'b0;
            end
         end
         default: begin
            state_s     = ST_IDLE;
            cnt_s       = CNT_ZERO;
            from_post_s = 1'b0;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      dq_d0_s    = DQ_IDLE;
      dq_d1_s    = DQ_IDLE;
      dm_d0_s    = DM_IDLE;
      dm_d1_s    = DM_IDLE;
      dqs_d0_s   = 1'b0;
      dqs_d1_s   = 1'b0;
      dq_oe_s    = 1'b0;
      dqs_oe_s   = 1'b0;
      busy_s     = 1'b0;
      underrun_s = underrun_r;
      // Entering or staying in BURST always follows a data request, so the
      // beat accepted now is launched in the next cycle; a missing beat is
      // launched as fully masked zeros.
      if ((state_s == ST_BURST) && take_s) begin
         dq_d0_s = di[DQW-1:0];
         dq_d1_s = di[2*DQW-1:DQW];
         dm_d0_s = dm[DMW-1:0];
         dm_d1_s = dm[2*DMW-1:DMW];
      end else begin
         dq_d0_s = DQ_IDLE;
         dq_d1_s = DQ_IDLE;
         dm_d0_s = DM_IDLE;
         dm_d1_s = DM_IDLE;
      end
      dq_oe_s  = (state_s == ST_BURST);
      dqs_d0_s = (state_s == ST_BURST);
      dqs_d1_s = 1'b0;
      // From IDLE only the last preamble cycle drives DQS low; when chained
      // from a postamble DQS is held through the whole preamble.
      dqs_oe_s = ((state_s == ST_PRE) && ((cnt_s == PRE_LAST) || from_post_s)) ||
                 (state_s == ST_BURST) || (state_s == ST_POST);
      busy_s   = (state_s != ST_IDLE);
      // A new underrun takes priority over a clear in the same cycle.
      if (miss_s) begin
         underrun_s = 1'b1;
      end else if (underrun_clr) begin
         underrun_s = 1'b0;
      end else begin
         underrun_s = underrun_r;
      end
   end

   // Sequencer state register with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (sdram_rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         from_post_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         from_post_r <= from_post_s;
      end
   end

   // Registered launch outputs; reset leaves the bus idle and masked.
   always_ff @(posedge sys_clk) begin
      if (sdram_rst) begin
         dq_d0_r    <= DQ_IDLE;
         dq_d1_r    <= DQ_IDLE;
         dm_d0_r    <= DM_IDLE;
         dm_d1_r    <= DM_IDLE;
         dqs_d0_r   <= 1'b0;
         dqs_d1_r   <= 1'b0;
         dq_oe_r    <= 1'b0;
         dqs_oe_r   <= 1'b0;
         busy_r     <= 1'b0;
         underrun_r <= 1'b0;
      end else begin
         dq_d0_r    <= dq_d0_s;
         dq_d1_r    <= dq_d1_s;
         dm_d0_r    <= dm_d0_s;
         dm_d1_r    <= dm_d1_s;
         dqs_d0_r   <= dqs_d0_s;
         dqs_d1_r   <= dqs_d1_s;
         dq_oe_r    <= dq_oe_s;
         dqs_oe_r   <= dqs_oe_s;
         busy_r     <= busy_s;
         underrun_r <= underrun_s;
      end
   end

   assign write_ready = write_ready_s;
   assign di_ready    = di_ready_s;
   assign dq_d0       = dq_d0_r;
   assign dq_d1       = dq_d1_r;
   assign dm_d0       = dm_d0_r;
   assign dm_d1       = dm_d1_r;
   assign dqs_d0      = dqs_d0_r;
   assign dqs_d1      = dqs_d1_r;
   assign dq_oe       = dq_oe_r;
   assign dqs_oe      = dqs_oe_r;
   assign busy        = busy_r;
   assign underrun    = underrun_r;

endmodule

// File: tb/tb_hpdmc_wrdatapath.sv
// Bench for hpdmc_wrdatapath: two instances (WL=1/BL4/x32 and WL=3/BL8/x16)
// compared every cycle against a schedule-based model, plus directed
// literal expectations.
module tb_hpdmc_wrdatapath;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        ws_a = 1'b0, dv_a = 1'b0, clr_a = 1'b0;
   logic [63:0] di_a = 64'h0;
   logic [7:0]  dm_a = 8'h0;
   logic        wr_a, rdy_a, qs0_a, qs1_a, qoe_a, qsoe_a, busy_a, ur_a;
   logic [31:0] d0_a, d1_a;
   logic [3:0]  m0_a, m1_a;

   logic        ws_b = 1'b0, dv_b = 1'b0, clr_b = 1'b0;
   logic [31:0] di_b = 32'h0;
   logic [3:0]  dm_b = 4'h0;
   logic        wr_b, rdy_b, qs0_b, qs1_b, qoe_b, qsoe_b, busy_b, ur_b;
   logic [15:0] d0_b, d1_b;
   logic [1:0]  m0_b, m1_b;

   always #5 clk = ~clk;

   hpdmc_wrdatapath #(.DQW(32), .WL_CYCLES(1), .BURST_CYCLES(2)) dut_a (
      .sys_clk(clk), .sdram_rst(rst), .write_start(ws_a), .write_ready(wr_a),
      .di_valid(dv_a), .di_ready(rdy_a), .di(di_a), .dm(dm_a),
      .dq_d0(d0_a), .dq_d1(d1_a), .dm_d0(m0_a), .dm_d1(m1_a),
      .dqs_d0(qs0_a), .dqs_d1(qs1_a), .dq_oe(qoe_a), .dqs_oe(qsoe_a),
      .busy(busy_a), .underrun(ur_a), .underrun_clr(clr_a));

   hpdmc_wrdatapath #(.DQW(16), .WL_CYCLES(3), .BURST_CYCLES(4)) dut_b (
      .sys_clk(clk), .sdram_rst(rst), .write_start(ws_b), .write_ready(wr_b),
      .di_valid(dv_b), .di_ready(rdy_b), .di(di_b), .dm(dm_b),
      .dq_d0(d0_b), .dq_d1(d1_b), .dm_d0(m0_b), .dm_d1(m1_b),
      .dqs_d0(qs0_b), .dqs_d1(qs1_b), .dq_oe(qoe_b), .dqs_oe(qsoe_b),
      .busy(busy_b), .underrun(ur_b), .underrun_clr(clr_b));

   localparam int NOSTART = -100000;

   // Model: each burst is described by the cycle its write was accepted in;
   // the phase of any later cycle follows from the offset to that cycle.
   int          cyc = 0;
   int          start_m [2];
   bit          fp_m [2];
   bit          ur_m [2];
   logic [31:0] e_d0 [2];
   logic [31:0] e_d1 [2];
   logic [3:0]  e_m0 [2];
   logic [3:0]  e_m1 [2];
   bit          e_busy [2];
   bit          e_qoe [2];
   bit          e_qsoe [2];
   bit          e_qs0 [2];
   bit          mvalid = 1'b0;
   int          errs = 0;
   int          checks = 0;

   function automatic int wl(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int bc(int i);
      return (i == 0) ? 2 : 4;
   endfunction

   // 0 idle, 1 preamble, 2 burst, 3 postamble
   function automatic int ph(int i, int c, int s);
      int k;
      k = c - s;
      if (k >= 1 && k <= wl(i)) return 1;
      if (k > wl(i) && k <= wl(i) + bc(i)) return 2;
      if (k == wl(i) + bc(i) + 1) return 3;
      return 0;
   endfunction

   function automatic bit want_beat(int i, int c, int s);
      int p;
      int k;
      p = ph(i, c, s);
      k = c - s;
      return (p == 1 || p == 2) && k >= wl(i) && k < wl(i) + bc(i);
   endfunction

   task automatic chk(int i, string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL cfg%0d %s: got %0h expected %0h (cycle %0d)", i, name, act, exp, cyc);
      end
   endtask

   // Advance the model over the clock edge just taken, using the inputs
   // that were presented during the cycle before it.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         bit          ws, dv, clr, rdy;
         logic [31:0] lo, hi;
         logic [3:0]  mlo, mhi, ones;
         int          pn, np, ns, k1;
         ws   = (i == 0) ? ws_a : ws_b;
         dv   = (i == 0) ? dv_a : dv_b;
         clr  = (i == 0) ? clr_a : clr_b;
         lo   = (i == 0) ? di_a[31:0] : {16'h0, di_b[15:0]};
         hi   = (i == 0) ? di_a[63:32] : {16'h0, di_b[31:16]};
         mlo  = (i == 0) ? dm_a[3:0] : {2'b00, dm_b[1:0]};
         mhi  = (i == 0) ? dm_a[7:4] : {2'b00, dm_b[3:2]};
         ones = (i == 0) ? 4'hF : 4'h3;
         if (rst) begin
            start_m[i] = NOSTART;
            fp_m[i] = 1'b0; ur_m[i] = 1'b0;
            e_d0[i] = 32'h0; e_d1[i] = 32'h0; e_m0[i] = ones; e_m1[i] = ones;
            e_busy[i] = 1'b0; e_qoe[i] = 1'b0; e_qsoe[i] = 1'b0; e_qs0[i] = 1'b0;
         end else begin
            pn  = ph(i, cyc, start_m[i]);
            rdy = want_beat(i, cyc, start_m[i]);
            ns  = start_m[i];
            if (ws && (pn == 0 || pn == 3)) begin
               ns = cyc;
               fp_m[i] = (pn == 3);
            end
            np = ph(i, cyc + 1, ns);
            k1 = cyc + 1 - ns;
            e_busy[i] = (np != 0);
            e_qoe[i]  = (np == 2);
            e_qs0[i]  = (np == 2);
            e_qsoe[i] = (np == 2) || (np == 3) || (np == 1 && (k1 == wl(i) || fp_m[i]));
            if (np == 2 && rdy && dv) begin
               e_d0[i] = lo; e_d1[i] = hi; e_m0[i] = mlo; e_m1[i] = mhi;
            end else begin
               e_d0[i] = 32'h0; e_d1[i] = 32'h0; e_m0[i] = ones; e_m1[i] = ones;
            end
            if (rdy && !dv) ur_m[i] = 1'b1;
            else if (clr) ur_m[i] = 1'b0;
            start_m[i] = ns;
         end
      end
      if (rst) mvalid = 1'b1;
      cyc++;
   endtask

   task automatic compare();
      if (mvalid) begin
         chk(0, "dq_d0", d0_a, e_d0[0]);
         chk(0, "dq_d1", d1_a, e_d1[0]);
         chk(0, "dm_d0", m0_a, e_m0[0]);
         chk(0, "dm_d1", m1_a, e_m1[0]);
         chk(0, "dqs_d0", qs0_a, e_qs0[0]);
         chk(0, "dqs_d1", qs1_a, 1'b0);
         chk(0, "dq_oe", qoe_a, e_qoe[0]);
         chk(0, "dqs_oe", qsoe_a, e_qsoe[0]);
         chk(0, "busy", busy_a, e_busy[0]);
         chk(0, "underrun", ur_a, ur_m[0]);
         chk(0, "di_ready", rdy_a, want_beat(0, cyc, start_m[0]));
         chk(0, "write_ready", wr_a, ph(0, cyc, start_m[0]) == 0 || ph(0, cyc, start_m[0]) == 3);
         chk(1, "dq_d0", d0_b, e_d0[1][15:0]);
         chk(1, "dq_d1", d1_b, e_d1[1][15:0]);
         chk(1, "dm_d0", m0_b, e_m0[1][1:0]);
         chk(1, "dm_d1", m1_b, e_m1[1][1:0]);
         chk(1, "dqs_d0", qs0_b, e_qs0[1]);
         chk(1, "dqs_d1", qs1_b, 1'b0);
         chk(1, "dq_oe", qoe_b, e_qoe[1]);
         chk(1, "dqs_oe", qsoe_b, e_qsoe[1]);
         chk(1, "busy", busy_b, e_busy[1]);
         chk(1, "underrun", ur_b, ur_m[1]);
         chk(1, "di_ready", rdy_b, want_beat(1, cyc, start_m[1]));
         chk(1, "write_ready", wr_b, ph(1, cyc, start_m[1]) == 0 || ph(1, cyc, start_m[1]) == 3);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      compare();
   endtask

   logic [63:0] beat_a0 = 64'h89AB_CDEF_0123_4567;
   logic [63:0] beat_a1 = 64'h7654_3210_FEDC_BA98;
   logic [31:0] beats_b [4] = '{32'hA1B2_C3D4, 32'h0F1E_2D3C, 32'h5566_7788, 32'h99AA_BBCC};

   initial begin
      int npa, npb;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Single write on both instances, data always available.
      npa = 0; npb = 0;
      ws_a = 1'b1; ws_b = 1'b1; dv_a = 1'b1; dv_b = 1'b1; di_a = beat_a0;
      tick();
      for (int t = 1; t <= 9; t++) begin
         case (t)
            1: begin
               chk(0, "lit c1 dqs_oe", qsoe_a, 1'b1);
               chk(0, "lit c1 dq_oe", qoe_a, 1'b0);
               chk(1, "lit c1 dqs_oe", qsoe_b, 1'b0);
               chk(1, "lit c1 busy", busy_b, 1'b1);
            end
            2: begin
               chk(0, "lit c2 dq_d0", d0_a, 32'h0123_4567);
               chk(0, "lit c2 dq_d1", d1_a, 32'h89AB_CDEF);
               chk(0, "lit c2 dqs_d0", qs0_a, 1'b1);
               chk(1, "lit c2 dqs_oe", qsoe_b, 1'b0);
            end
            3: begin
               chk(0, "lit c3 dq_d0", d0_a, 32'hFEDC_BA98);
               chk(0, "lit c3 dq_d1", d1_a, 32'h7654_3210);
               chk(1, "lit c3 dqs_oe", qsoe_b, 1'b1);
               chk(1, "lit c3 dq_oe", qoe_b, 1'b0);
            end
            4: begin
               chk(0, "lit c4 dqs_oe", qsoe_a, 1'b1);
               chk(0, "lit c4 dq_oe", qoe_a, 1'b0);
               chk(0, "lit c4 dm_d0", m0_a, 4'hF);
               chk(1, "lit c4 dq_d0", d0_b, 16'hC3D4);
               chk(1, "lit c4 dq_d1", d1_b, 16'hA1B2);
            end
            5: begin
               chk(0, "lit c5 busy", busy_a, 1'b0);
               chk(0, "lit c5 dqs_oe", qsoe_a, 1'b0);
               chk(1, "lit c5 dq_d0", d0_b, 16'h2D3C);
            end
            7: begin
               chk(1, "lit c7 dq_d0", d0_b, 16'hBBCC);
               chk(1, "lit c7 dq_d1", d1_b, 16'h99AA);
            end
            8: begin
               chk(1, "lit c8 dqs_oe", qsoe_b, 1'b1);
               chk(1, "lit c8 dq_oe", qoe_b, 1'b0);
               chk(1, "lit c8 dm_d0", m0_b, 2'b11);
            end
            9: chk(1, "lit c9 busy", busy_b, 1'b0);
            default: ;
         endcase
         npa += int'(rdy_a);
         npb += int'(rdy_b);
         ws_a = 1'b0; ws_b = 1'b0;
         di_a = (t == 1) ? beat_a0 : beat_a1;
         if (t >= 3 && t <= 6) di_b = beats_b[t-3];
         else di_b = 32'h0;
         tick();
      end
      chk(0, "lit di_ready pulses", npa, 2);
      chk(1, "lit di_ready pulses", npb, 4);
      repeat (2) tick();

      // Missing second beat, then clear the sticky flag.
      ws_a = 1'b1; dv_a = 1'b1; di_a = beat_a0; tick();
      ws_a = 1'b0; tick();
      dv_a = 1'b0; tick();
      chk(0, "lit ur dq_d0", d0_a, 32'h0);
      chk(0, "lit ur dm_d0", m0_a, 4'hF);
      chk(0, "lit ur dm_d1", m1_a, 4'hF);
      chk(0, "lit ur set", ur_a, 1'b1);
      dv_a = 1'b1; tick();
      chk(0, "lit ur sticky", ur_a, 1'b1);
      clr_a = 1'b1; tick();
      clr_a = 1'b0;
      chk(0, "lit ur cleared", ur_a, 1'b0);
      repeat (2) tick();

      // write_start held through PRE/BURST is ignored.
      npa = 0;
      ws_a = 1'b1;
      for (int t = 0; t < 4; t++) begin
         npa += int'(rdy_a);
         tick();
      end
      ws_a = 1'b0;
      for (int t = 0; t < 3; t++) begin
         npa += int'(rdy_a);
         tick();
      end
      chk(0, "lit ignored ws pulses", npa, 2);
      chk(0, "lit ignored ws idle", busy_a, 1'b0);

      // Back-to-back: second write issued in the postamble.
      ws_a = 1'b1; tick();
      ws_a = 1'b0;
      for (int t = 1; t <= 8; t++) begin
         chk(0, "lit b2b dqs_oe", qsoe_a, 1'b1);
         chk(0, "lit b2b busy", busy_a, 1'b1);
         ws_a = (t == 4);
         tick();
      end
      ws_a = 1'b0;
      chk(0, "lit b2b end", busy_a, 1'b0);
      repeat (2) tick();

      // Reset in the second burst cycle aborts the burst.
      ws_a = 1'b1; tick();
      ws_a = 1'b0; tick();
      tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      chk(0, "lit rst busy", busy_a, 1'b0);
      chk(0, "lit rst dqs_oe", qsoe_a, 1'b0);
      chk(0, "lit rst dq_oe", qoe_a, 1'b0);
      chk(0, "lit rst dm_d0", m0_a, 4'hF);
      chk(0, "lit rst dq_d0", d0_a, 32'h0);

      // Randomised traffic.
      for (int n = 0; n < 4000; n++) begin
         ws_a  = ($urandom % 3) == 0;
         dv_a  = ($urandom % 8) != 0;
         clr_a = ($urandom % 16) == 0;
         di_a  = {$urandom, $urandom};
         dm_a  = 8'($urandom);
         ws_b  = ($urandom % 4) == 0;
         dv_b  = ($urandom % 8) != 0;
         clr_b = ($urandom % 16) == 0;
         di_b  = $urandom;
         dm_b  = 4'($urandom);
         rst   = ($urandom % 300) == 0;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/hpdmc_wrdatapath.md
Name: hpdmc_wrdatapath

Overview:
- Write-data launch stage of the HPDMC DDR controller; sits directly upstream of the per-byte DDR output register banks.
- On each write command from the command scheduler, sequences DQS preamble, burst and postamble, and presents rising/falling-edge halves of DQ, DM and DQS.
- Drives the DQ/DQS output-enable controls and pulls write data from the data-buffer handshake one cycle ahead of launch.
- Underrun detection: missing data is masked, never stalled, because DRAM write timing is fixed.

Parameters:
DQW, 32, DRAM data bus width in bits (16 or 32)
DMW, DQW/8, data-mask width, one bit per byte lane
WL_CYCLES, 1, sys_clk cycles from write_start to first burst cycle (>=1)
BURST_CYCLES, 2, sys_clk cycles per burst (BL4=2, BL8=4, >=1)

Ports:
sys_clk  input  1  controller clock; all state updates on its rising edge
sdram_rst  input  1  synchronous reset, active-high
write_start  input  1  one-cycle pulse: WRITE command issued this cycle
write_ready  output  1  write_start is accepted this cycle
di_valid  input  1  write buffer holds a beat
di_ready  output  1  beat consumed this cycle
di  input  2*DQW  beat data; [DQW-1:0] rising edge, [2*DQW-1:DQW] falling edge
dm  input  2*DMW  beat mask, 1 = byte not written; same split as di
dq_d0  output  DQW  rising-edge DQ to output registers
dq_d1  output  DQW  falling-edge DQ
dm_d0  output  DMW  rising-edge DM
dm_d1  output  DMW  falling-edge DM
dqs_d0  output  1  rising-edge DQS level
dqs_d1  output  1  falling-edge DQS level
dq_oe  output  1  DQ/DM output enable
dqs_oe  output  1  DQS output enable
busy  output  1  state != IDLE
underrun  output  1  sticky: a burst beat lacked data
underrun_clr  input  1  clears underrun

Behaviour:
- Reset: state=IDLE, counters 0; dq_d0/d1=0, dm_d0/d1=all ones, dqs_d0/d1=0, dq_oe=0, dqs_oe=0, underrun=0, busy=0. Reset mid-burst aborts it; outputs take reset values after the edge.
- All outputs except write_ready and di_ready are registered. write_ready and di_ready are combinational from state and counter only.
- States:
  - IDLE
  - PRE: WL_CYCLES cycles
  - BURST: BURST_CYCLES cycles
  - POST: 1 cycle
- write_ready = (IDLE or POST). write_start while write_ready=0 is ignored; the command scheduler guarantees spacing.
- Transitions:
  - IDLE + write_start -> PRE.
  - PRE last cycle -> BURST.
  - BURST last cycle -> POST.
  - POST + write_start -> PRE, otherwise IDLE.
- Cycle timing with write_start sampled at edge E0, cycle n = after edge En:
  - PRE occupies 1..WL; BURST occupies WL+1..WL+BURST_CYCLES; POST occupies the following cycle.
- dqs_oe:
  - From IDLE, asserted only in the final PRE cycle (preamble, dqs_d0=dqs_d1=0).
  - From POST, held high through PRE.
  - High in BURST and POST.
- BURST: dq_oe=1, dqs_d0=1, dqs_d1=0. POST: dq_oe=0, dqs_oe=1, dqs_d0=dqs_d1=0, dm=all ones.
- di_ready=1 in the final PRE cycle and every non-final BURST cycle, so exactly BURST_CYCLES beats are requested per burst. A beat accepted in cycle n is on dq_d*/dm_d* in cycle n+1.
- Underrun: when di_ready=1 and di_valid=0:
  - next cycle drives dq=0, dm=all ones;
  - underrun is set;
  - the burst continues with no stall and no beat recount.
- underrun_clr clears underrun unless an underrun occurs the same cycle; set wins.
- Outside BURST: dq_d0/d1 hold 0 and dm_d0/d1 hold all ones.
- busy is high from the cycle after write_start through POST.

Test Plan:
- Single write, WL=1, BURST=2, di_valid always 1, beats A/B -> cycle1 dqs_oe=1 dq_oe=0; cycles 2-3 dq_d0/d1 = A then B halves with dqs_d0=1; cycle4 dqs_oe=1 dq_oe=0; cycle5 idle; exactly 2 di_ready pulses.
- Back-to-back: write_start in POST -> dqs_oe stays 1 continuously; second burst starts WL cycles later; no IDLE between bursts.
- di_valid=0 on second beat -> cycle3 dm_d0/d1 all ones, dq=0; underrun=1 and persists; underrun_clr pulse -> 0.
- write_start during PRE/BURST -> ignored: only one burst occurs and di_ready count is unchanged.
- sdram_rst asserted in burst cycle 2 -> next cycle all outputs at reset values, busy=0; a fresh write_start then runs a full normal burst.
- WL=3, BURST=4, DQW=16 -> preamble only in cycle3; burst cycles 4-7; 4 beats with correct 16-bit splits; POST in cycle8.
